map_hud_drawer: RTL and testbench

- Parametrised screen-region drawer. On request, streams a selected background map, or the HUD strip with a live health bar, from on-chip ROMs into VGA adapter memory, one pixel per clock.
- Sits between control (draw requests, done pulses) and the VGA adapter write port. Replaces the single-map, fixed-HUD drawer.
- Adds multi-map select, request queuing and a health-bar overlay.

---
 rtl/map_hud_drawer.sv | 168 ++++++++++++++++
 tb/tb_map_hud_drawer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/map_hud_drawer.sv
// Streams a selected background map or the HUD strip (with health-bar overlay)
// from on-chip ROMs into VGA adapter memory, one pixel per clock.
module map_hud_drawer #(
  parameter int unsigned MAP_W    = 320,
  parameter int unsigned MAP_H    = 192,
  parameter int unsigned HUD_H    = 48,
  parameter int unsigned NUM_MAPS = 4,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned BAR_X0   = 16,
  parameter int unsigned BAR_Y0   = 8,
  parameter int unsigned BAR_H    = 8,
  parameter int unsigned BAR_STEP = 8,
  parameter int unsigned HEALTH_W = 4,
  parameter logic [COLOUR_W-1:0] BAR_COLOUR = 3'b100,
  localparam int unsigned SEL_W  = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
  localparam int unsigned MAP_AW = $clog2(NUM_MAPS * MAP_W * MAP_H),
  localparam int unsigned HUD_AW = $clog2(MAP_W * HUD_H)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                draw_map_i,
  input  logic                draw_hud_i,
  input  logic [SEL_W-1:0]    map_sel_i,
  input  logic [HEALTH_W-1:0] health_i,
  output logic [MAP_AW-1:0]   map_rom_addr_o,
  input  logic [COLOUR_W-1:0] map_rom_data_i,
  output logic [HUD_AW-1:0]   hud_rom_addr_o,
  input  logic [COLOUR_W-1:0] hud_rom_data_i,
  output logic [8:0]          x_pos_o,
  output logic [7:0]          y_pos_o,
  output logic [COLOUR_W-1:0] colour_o,
  output logic                vga_write_o,
  output logic                busy_o,
  output logic                draw_map_done_o,
  output logic                draw_hud_done_o
);

  typedef enum logic [1:0] {StIdle, StMap, StHud, StFlush} state_e;

  state_e                state_q, state_d;
  logic [8:0]            x_q, x_d;
  logic [7:0]            y_q, y_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [HEALTH_W-1:0]   health_q, health_d;
  logic                  map_pend_q, map_pend_d;
  logic                  hud_pend_q, hud_pend_d;
  logic                  kind_map_q, kind_map_d;
  logic                  wr_q, wr_d;
  logic                  src_map_q, src_map_d;
  logic                  bar_q, bar_d;
  logic [8:0]            px_q, px_d;
  logic [7:0]            py_q, py_d;
  logic                  map_done_q, map_done_d;
  logic                  hud_done_q, hud_done_d;

  logic                  scanning;
  logic [SEL_W-1:0]      sel_clamped;
  logic [31:0]           rows_last;

  assign scanning    = (state_q == StMap) || (state_q == StHud);
  assign sel_clamped = (32'(map_sel_i) >= NUM_MAPS) ? SEL_W'(NUM_MAPS - 1) : map_sel_i;
  assign rows_last   = (state_q == StMap) ? MAP_H - 1 : HUD_H - 1;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    sel_d      = sel_q;
    health_d   = health_q;
    kind_map_d = kind_map_q;
    map_pend_d = map_pend_q | draw_map_i;
    hud_pend_d = hud_pend_q | draw_hud_i;
    unique case (state_q)
      StIdle: begin
        if (map_pend_q || draw_map_i) begin
          state_d    = StMap;
          map_pend_d = 1'b0;
          sel_d      = sel_clamped;
          kind_map_d = 1'b1;
          x_d        = '0;
          y_d        = '0;
        end else if (hud_pend_q || draw_hud_i) begin
          state_d    = StHud;
          hud_pend_d = 1'b0;
          health_d   = health_i;
          kind_map_d = 1'b0;
          x_d        = '0;
          y_d        = '0;
        end
      end
      StMap, StHud: begin
        if (32'(x_q) == MAP_W - 1) begin
          x_d = '0;
          if (32'(y_q) == rows_last) state_d = StFlush;
          else y_d = y_q + 8'd1;
        end else begin
          x_d = x_q + 9'd1;
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pixel pipeline stage: aligns coordinates/overlay with the 1-cycle ROM latency.
  // Range checks use unsigned wrap-around so below-range values fail the compare.
  always_comb begin
    wr_d       = scanning;
    src_map_d  = (state_q == StMap);
    px_d       = x_q;
    py_d       = (state_q == StHud) ? 8'(MAP_H + 32'(y_q)) : y_q;
    bar_d      = (state_q == StHud) &&
                 ((32'(y_q) - BAR_Y0) < BAR_H) &&
                 ((32'(x_q) - BAR_X0) < 32'(health_q) * BAR_STEP);
    map_done_d = (state_q == StFlush) && kind_map_q;
    hud_done_d = (state_q == StFlush) && !kind_map_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= '0;
      health_q   <= '0;
      map_pend_q <= 1'b0;
      hud_pend_q <= 1'b0;
      kind_map_q <= 1'b0;
      wr_q       <= 1'b0;
      src_map_q  <= 1'b0;
      bar_q      <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      map_done_q <= 1'b0;
      hud_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sel_q      <= sel_d;
      health_q   <= health_d;
      map_pend_q <= map_pend_d;
      hud_pend_q <= hud_pend_d;
      kind_map_q <= kind_map_d;
      wr_q       <= wr_d;
      src_map_q  <= src_map_d;
      bar_q      <= bar_d;
      px_q       <= px_d;
      py_q       <= py_d;
      map_done_q <= map_done_d;
      hud_done_q <= hud_done_d;
    end
  end

  assign map_rom_addr_o = (state_q == StMap) ?
      MAP_AW'(32'(sel_q) * MAP_W * MAP_H + 32'(y_q) * MAP_W + 32'(x_q)) : '0;
  assign hud_rom_addr_o = (state_q == StHud) ? HUD_AW'(32'(y_q) * MAP_W + 32'(x_q)) : '0;

  assign vga_write_o     = wr_q;
  assign x_pos_o         = wr_q ? px_q : '0;
  assign y_pos_o         = wr_q ? py_q : '0;
  assign colour_o        = !wr_q ? '0 : bar_q ? BAR_COLOUR :
                           src_map_q ? map_rom_data_i : hud_rom_data_i;
  assign busy_o          = (state_q != StIdle) || map_done_q || hud_done_q;
  assign draw_map_done_o = map_done_q;
  assign draw_hud_done_o = hud_done_q;

endmodule

// File: tb/tb_map_hud_drawer.sv
// Scoreboard bench for map_hud_drawer with small geometry and address-LSB ROM models.
module tb_map_hud_drawer;

  logic       clk = 1'b0;
  logic       reset;
  logic       draw_map, draw_hud;
  logic       map_sel;
  logic [3:0] health;
  logic [5:0] map_addr;
  logic [2:0] map_data;
  logic [3:0] hud_addr;
  logic [2:0] hud_data;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  logic [2:0] colour;
  logic       vga_write, busy, map_done, hud_done;

  int checks = 0;
  int errors = 0;

  // kind: 0 = pixel write, 1 = map done, 2 = hud done
  typedef struct {
    int kind;
    int x;
    int y;
    int c;
  } ev_t;

  ev_t sb[$];
  logic prev_wr = 1'b0;

  map_hud_drawer #(
    .MAP_W(8), .MAP_H(4), .HUD_H(2), .NUM_MAPS(2), .COLOUR_W(3),
    .BAR_X0(1), .BAR_Y0(0), .BAR_H(1), .BAR_STEP(2), .HEALTH_W(4),
    .BAR_COLOUR(3'b100)
  ) dut (
    .clock_i(clk),
    .reset_i(reset),
    .draw_map_i(draw_map),
    .draw_hud_i(draw_hud),
    .map_sel_i(map_sel),
    .health_i(health),
    .map_rom_addr_o(map_addr),
    .map_rom_data_i(map_data),
    .hud_rom_addr_o(hud_addr),
    .hud_rom_data_i(hud_data),
    .x_pos_o(x_pos),
    .y_pos_o(y_pos),
    .colour_o(colour),
    .vga_write_o(vga_write),
    .busy_o(busy),
    .draw_map_done_o(map_done),
    .draw_hud_done_o(hud_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    map_data <= map_addr[2:0];
    hud_data <= hud_addr[2:0];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input int k, input int x, input int y, input int c);
    ev_t e;
    e.kind = k;
    e.x = x;
    e.y = y;
    e.c = c;
    return e;
  endfunction

  task automatic push_map(input int sel);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        sb.push_back(mk(0, x, y, (sel * 32 + y * 8 + x) % 8));
    sb.push_back(mk(1, 0, 0, 0));
  endtask

  task automatic push_hud(input int h);
    int c;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 8; x++) begin
        c = (y * 8 + x) % 8;
        if (y == 0 && x >= 1 && x < 1 + h * 2) c = 4;
        sb.push_back(mk(0, x, 4 + y, c));
      end
    sb.push_back(mk(2, 0, 0, 0));
  endtask

  // Monitor: every write or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    int  nev;
    if (reset) begin
      prev_wr = 1'b0;
    end else begin
      nev = int'(vga_write) + int'(map_done) + int'(hud_done);
      if (nev > 1) begin
        checks++;
        errors++;
        $display("FAIL overlap wr=%0b md=%0b hd=%0b want one event", vga_write, map_done,
                 hud_done);
      end else if (nev == 1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event wr=%0b md=%0b hd=%0b x=%0d y=%0d want none",
                   vga_write, map_done, hud_done, x_pos, y_pos);
        end else begin
          e = sb.pop_front();
          if (e.kind == 0) begin
            if (!vga_write || int'(x_pos) != e.x || int'(y_pos) != e.y || int'(colour) != e.c) begin
              errors++;
              $display("FAIL pixel got wr=%0b md=%0b hd=%0b (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                       vga_write, map_done, hud_done, x_pos, y_pos, colour, e.x, e.y, e.c);
            end
          end else begin
            if ((e.kind == 1 && !map_done) || (e.kind == 2 && !hud_done) || !prev_wr) begin
              errors++;
              $display("FAIL done got wr=%0b md=%0b hd=%0b prev_wr=%0b want kind %0d after write",
                       vga_write, map_done, hud_done, prev_wr, e.kind);
            end
          end
        end
      end
      prev_wr = vga_write;
    end
  end

  task automatic pulse(input logic m, input logic h, input logic sel, input logic [3:0] hl);
    @(posedge clk); #1;
    draw_map = m;
    draw_hud = h;
    map_sel  = sel;
    health   = hl;
    @(posedge clk); #1;
    draw_map = 1'b0;
    draw_hud = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_timeout"}, int'(n < 400), 1);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_busy_low"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    draw_map = 1'b0;
    draw_hud = 1'b0;
    map_sel = 1'b0;
    health = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", int'(vga_write), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dones", int'({map_done, hud_done}), 0);
    chk("rst_addr", int'({map_addr, hud_addr}), 0);
    chk("rst_pix", int'({x_pos, y_pos, colour}), 0);
    reset = 1'b0;

    // Map 1 with latency check; map_sel change mid-draw must be ignored
    push_map(1);
    pulse(1'b1, 1'b0, 1'b1, 4'd0);
    map_sel = 1'b0;
    chk("lat_busy", int'(busy), 1);
    chk("lat_nowrite", int'(vga_write), 0);
    chk("lat_addr", int'(map_addr), 32);
    @(posedge clk); #1;
    chk("lat_first_write", int'(vga_write), 1);
    drain("map1");

    // HUD health 2; health change mid-draw ignored
    push_hud(2);
    pulse(1'b0, 1'b1, 1'b0, 4'd2);
    health = 4'd7;
    drain("hud2");

    // Simultaneous requests: map first, then HUD
    push_map(0);
    push_hud(3);
    pulse(1'b1, 1'b1, 1'b0, 4'd3);
    drain("both");

    // draw_map held 10 cycles during a HUD draw collapses to one map draw
    push_hud(1);
    push_map(1);
    pulse(1'b0, 1'b1, 1'b0, 4'd1);
    repeat (2) @(posedge clk);
    #1;
    draw_map = 1'b1;
    map_sel  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    draw_map = 1'b0;
    drain("held");
    repeat (20) @(posedge clk);
    #1;
    chk("held_no_extra", int'(busy), 0);

    // Reset at the 10th write aborts without a done pulse
    push_map(1);
    pulse(1'b1, 1'b0, 1'b1, 4'd0);
    n = 0;
    for (int k = 0; k < 50 && n < 10; k++) begin
      @(posedge clk); #1;
      if (vga_write) n++;
    end
    chk("rst_reach10", n, 10);
    reset = 1'b1;
    #1;
    chk("arst_write", int'(vga_write), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_addr", int'(map_addr), 0);
    chk("arst_pix", int'({x_pos, y_pos, colour}), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", int'(busy), 0);
    push_map(0);
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    drain("restart");

    // health 0: no bar; health 15: bar clipped at x=7, no wrap to x=0
    push_hud(0);
    pulse(1'b0, 1'b1, 1'b0, 4'd0);
    drain("hud0");
    push_hud(15);
    pulse(1'b0, 1'b1, 1'b0, 4'd15);
    drain("hud15");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
